uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Buffered UART transmitter. Serialises bytes written by upstream logic through a valid/ready port into standard 8-N-1 frames on tx (8-E/O-1 with the optional parity feature). It is the transmit end paired with the team's UART receiver path. A small synchronous FIFO decouples producer bursts from line rate, and frames go out back-to-back with no idle gap while data is queued.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUDRATE, 115200, line rate in bit/s; BITPERIOD = CLK_FREQ / BAUDRATE (integer division, 434 at defaults)
FIFO_DEPTH, 16, FIFO entries; power of 2, minimum 2
STOP_BITS, 1, number of stop bits; legal values 1 or 2
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only when UART_TX_PARITY_EN is defined

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
din  input  8  byte to transmit
din_valid  input  1  din is valid this cycle
din_ready  output  1  FIFO can accept a byte; equals !full
tx  output  1  serial line out, idle high, registered
busy  output  1  high while a frame is on the line or the FIFO is non-empty
fifo_level  output  $clog2(FIFO_DEPTH)+1  number of bytes queued, excluding the byte in flight

Behaviour:
- Reset (async, active-high): tx=1, busy=0, fifo_level=0, din_ready=1, FSM=IDLE, all counters 0. Asserting rst mid-frame aborts the frame and drives tx high immediately. Queued bytes are discarded.
- Write: a byte is accepted on a rising edge when din_valid && din_ready. When the FIFO is full, din_ready=0 and pushes are refused, even if a pop occurs in the same cycle.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop one byte into an 8-bit shift register and go to START. tx is driven 0 on the same edge.
  - START: tx=0 for BITPERIOD clocks, then DATA.
  - DATA: 8 bits, LSB first, each held for BITPERIOD clocks. A bit counter runs 0..7. After bit 7 ends, go to PARITY if enabled, otherwise STOP.
  - STOP: tx=1 for STOP_BITS*BITPERIOD clocks. At the end, if the FIFO is non-empty, pop and go directly to START (tx=0 on that edge, no extra idle clock). Otherwise go to IDLE.
- Latency: for a byte accepted into an empty FIFO with FSM in IDLE at edge E0, tx falls at edge E0+1.
- Frame length is exactly (10 + STOP_BITS - 1)*BITPERIOD clocks, plus BITPERIOD when parity is enabled.
- Baud counter is 16 bits wide. It counts 0..BITPERIOD-1 in every non-IDLE state and wraps to 0 at each bit boundary. BITPERIOD must be >= 2.
- fifo_level: incremented on push and decremented on pop. Simultaneous push and pop leaves it unchanged. FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- busy = (FSM != IDLE) || (fifo_level != 0). It is registered/derived so that it is high from the edge after the first accept until the final stop bit completes.
- din is sampled only on an accepting edge. din is ignored when din_valid=0.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It holds tx = ^data (even, PARITY_ODD=0) or ~^data (odd, PARITY_ODD=1) for BITPERIOD clocks. Frame is 11 bits at STOP_BITS=1.
- Not defined: no PARITY state or logic is generated. PARITY_ODD is unused. Frame is 10 bits at STOP_BITS=1.

Test Plan:
All tests use CLK_FREQ=1_000_000 and BAUDRATE=100_000 (BITPERIOD=10).
1. Reset then idle 100 clocks -> tx=1, busy=0, din_ready=1, fifo_level=0 throughout.
2. Single push of 0x55 -> tx falls 1 clock after accept. Line reads 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop), each level held 10 clocks. busy drops after 100 clocks.
3. Burst-push 0xA3, 0x00, 0xFF on consecutive cycles -> three frames with no idle gap (300 clocks of continuous framing). fifo_level peaks at 2. Decoded bytes match in order.
4. Hold din_valid=1 with FIFO_DEPTH=4 while transmitting -> din_ready=0 when fifo_level=4. No byte is lost or duplicated over 10 bytes.
5. Assert rst during data bit 3 of 0xF0 with 2 bytes queued -> tx=1 immediately, fifo_level=0. The next push transmits cleanly.
6. With UART_TX_PARITY_EN and PARITY_ODD=0, send 0x07 -> parity bit =1. With PARITY_ODD=1, send 0x07 -> parity bit =0. Frame is 110 clocks.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered 8-N-1 UART transmitter: a synchronous byte FIFO feeds a two-process framing FSM.
// Define UART_TX_PARITY_EN to insert a parity bit (even/odd selected by PARITY_ODD).
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUDRATE   = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BITPERIOD = CLK_FREQ / BAUDRATE;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int LW        = AW + 1;

  localparam logic [15:0]   BAUD_LAST  = 16'(BITPERIOD - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
  localparam logic          STOP_LAST  = 1'(STOP_BITS - 1);

  generate
    if (BITPERIOD < 2) begin : g_chk_baud
      $error("uart_tx_fifo: CLK_FREQ/BAUDRATE must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, minimum 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_chk_par
      $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [15:0]   r_baud;
  logic [2:0]    r_bitcnt;
  logic          r_stopcnt;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
`ifdef UART_TX_PARITY_EN
  logic          r_parity;
`endif

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_baud_end;
  logic          w_tx_next;
  logic [7:0]    w_rd_data;

  assign w_full     = (r_level == LEVEL_FULL);
  assign w_empty    = (r_level == '0);
  assign w_push     = din_valid && !w_full;
  assign w_baud_end = (r_baud == BAUD_LAST);
  assign w_rd_data  = r_mem[r_rptr];

  assign din_ready  = !w_full;
  assign tx         = r_tx;
  assign busy       = (r_state != S_IDLE) || !w_empty;
  assign fifo_level = r_level;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  // tx is registered from the next-state value, so the line level changes on the same edge as the state.
  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_tx_next = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_next    = S_START;
          w_tx_next = 1'b0;
        end
      end
      S_START: begin
        w_tx_next = 1'b0;
        if (w_baud_end) begin
          w_next    = S_DATA;
          w_tx_next = r_shift[0];
        end
      end
      S_DATA: begin
        w_tx_next = r_shift[0];
        if (w_baud_end) begin
          if (r_bitcnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_next    = S_PARITY;
            w_tx_next = r_parity;
`else
            w_next    = S_STOP;
            w_tx_next = 1'b1;
`endif
          end else begin
            w_tx_next = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        w_tx_next = r_parity;
        if (w_baud_end) begin
          w_next    = S_STOP;
          w_tx_next = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_baud_end && (r_stopcnt == STOP_LAST)) begin
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_next    = S_START;
            w_tx_next = 1'b0;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bitcnt  <= '0;
      r_stopcnt <= 1'b0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_tx    <= w_tx_next;

      if (r_state == S_IDLE || w_baud_end) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + 16'd1;
      end

      if (r_state == S_DATA && w_baud_end) begin
        r_bitcnt <= r_bitcnt + 3'd1;
        r_shift  <= {1'b0, r_shift[7:1]};
      end

      if (r_state == S_STOP && w_baud_end) begin
        r_stopcnt <= (r_stopcnt == STOP_LAST) ? 1'b0 : (r_stopcnt + 1'b1);
      end

      if (w_pop) begin
        r_shift <= w_rd_data;
        r_rptr  <= r_rptr + AW'(1);
`ifdef UART_TX_PARITY_EN
        r_parity <= (^w_rd_data) ^ 1'(PARITY_ODD);
`endif
      end

      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
